wb_ram_arbiter: RTL and testbench
=================================

# wb_ram_arbiter

Two-port Wishbone (classic cycle) slave that shares one single-port synchronous RAM (64 K × 16, 1-cycle registered read, `cen`/`wen` strobes) between two masters. It sits between the bus masters and the RAM macro. It grants bus ownership per Wishbone cycle (`cyc`), using round-robin on contention. It sequences every RAM access and returns `ack` with read data aligned to the RAM's one-cycle read latency.

## Interface
Parameters:
- `adr_width`, 16, RAM word-address width.
- `dat_width`, 16, data width.

Ports:
- `clk`, in, 1. Single clock for the block and the RAM.
- `rst`, in, 1. Synchronous, active-high reset.
- `m_cyc`, in, [2]. Per-master cycle request; held by a master to keep ownership.
- `m_stb`, in, [2]. Per-master transfer strobe.
- `m_we`, in, [2]. 1 = write, 0 = read.
- `m_adr`, in, [2][adr_width]. Word address.
- `m_dat_w`, in, [2][dat_width]. Write data.
- `m_dat_r`, out, [2][dat_width]. Read data; valid only while the matching `m_ack` is high.
- `m_ack`, out, [2]. One-cycle transfer acknowledge.
- `ram_a`, out, adr_width. RAM address.
- `ram_d`, out, dat_width. RAM write data.
- `ram_q`, in, dat_width. RAM read data, registered inside the RAM.
- `ram_cen`, out, 1. RAM cycle enable.
- `ram_wen`, out, 1. RAM write enable; only meaningful with `ram_cen`.

## Operation
- Registered state is `state ∈ {IDLE, GRANT, ACK}`, `owner` (1 bit) and `last` (1 bit, last released owner).
- **IDLE:**
  - If exactly one `m_cyc` is high, that master becomes `owner`.
  - If both are high, `owner = ~last`.
  - If either is high, go to GRANT. Otherwise stay in IDLE.
- **GRANT:**
  - If `m_cyc[owner]` = 0: set `last = owner` and go to IDLE.
  - Else if `m_stb[owner]` = 1: drive `ram_cen` = 1, `ram_wen = m_we[owner]`, `ram_a = m_adr[owner]`, `ram_d = m_dat_w[owner]` combinationally, then go to ACK.
  - Else stay in GRANT.
- **ACK:**
  - `m_ack[owner] = m_cyc[owner] & m_stb[owner]`.
  - `m_dat_r[owner] = ram_q`. Write acks also present `ram_q`; masters ignore it.
  - Go to GRANT unconditionally.
  - A master that drops `cyc` in ACK (abort) receives no ack. It is released from GRANT on the next cycle; a write already strobed still lands in RAM.
- The non-owner always sees `m_ack` = 0 and `m_dat_r` = 0. The owner sees `m_dat_r` = 0 outside ACK.
- Ownership is never preempted while `m_cyc[owner]` stays high. A master holding `cyc` can therefore do back-to-back accesses and read-modify-write.
- `ram_cen` = 0 in every state except GRANT with `m_stb[owner]` high. When `ram_cen` = 0, `ram_a`, `ram_d` and `ram_wen` are 0.

## Timing
- **Reset:** `state` = IDLE, `owner` = 0, `last` = 1, so master 0 wins the first contention. During the reset cycle all outputs are 0, including `ram_cen`.
- **First access of a cycle:** `cyc`/`stb` rise at edge N; grant at N+1; RAM strobed in cycle N+1; `ack` in cycle N+2.
- **Subsequent accesses while owned:** the strobe-to-ack latency is 1 cycle, and throughput is 1 transfer per 2 cycles. The cycle after an ack is always GRANT, so a master holding `stb` high immediately starts its next transfer.
- **Release:** `cyc` low in GRANT leads to IDLE on the next edge. A re-request is granted one cycle later, so there are at least 2 idle cycles between owners.
- **Simultaneous requests in IDLE:** resolved by `last` only. Identical request patterns alternate owners.
- **Read-after-write to the same address** by the same owner returns the new data, because RAM accesses are serialized.
- **`rst` mid-transfer:** the pending ack is dropped and the state returns to IDLE. A write strobed in the same cycle as `rst` is suppressed, because `ram_cen` is forced to 0.

## Structure
- Shared package `wb_ram_pkg`: holds the `state_t` enum (IDLE, GRANT, ACK) and the master count constant `n_masters = 2`.
- One natural sub-module, `rr_grant2`: a combinational two-way round-robin pick from `req[2]` and `last`, producing the winner index.
- The RAM macro is instantiated at the next level up and wired to the `ram_*` ports.

## Test plan
- **Single read after reset.** Pre-load RAM[0x1234] = 0xBEEF. Master 0 raises `cyc`/`stb`/`we=0`/`adr=0x1234` at edge 1. Required: `ram_cen` high in cycle 2, `m_ack[0]` high only in cycle 3, and `m_dat_r[0]` = 0xBEEF.
- **Burst under ownership.** Master 1 holds `cyc`/`stb` and performs writes 0x0001→A0, 0x0002→A1, then reads A0 and A1. Required: an ack every 2 cycles, reads return 0x0001 and 0x0002, and `m_ack[0]` stays 0 throughout.
- **Contention fairness.** Both masters raise `cyc` in the same cycle after reset, each doing one access and then dropping `cyc`, repeated 4 times. Required: grant order 0, 1, 0, 1.
- **No preemption.** Master 0 owns and holds `cyc` for 10 transfers while master 1 requests. Required: master 1 is granted exactly 2 cycles after master 0 drops `cyc`.
- **Abort and reset.**
  - Master 0 drops `cyc` in its ACK cycle. Required: `m_ack[0]` = 0 and the state returns to IDLE within 2 cycles.
  - Separately, assert `rst` in a strobe cycle of a write of 0x5555 to 0x0010 (RAM[0x0010] pre-loaded with 0xAAAA). Required: RAM[0x0010] is unchanged and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the two-master Wishbone RAM arbiter.
package wb_ram_pkg;

  localparam int n_masters = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to whichever master did not own the bus last.
module rr_grant2
  import wb_ram_pkg::*;
(
  input  logic [n_masters-1:0] req_i,
  input  logic                 last_i,
  output logic                 winner_o
);

  assign winner_o = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-port Wishbone classic slave sharing one single-port synchronous RAM,
// granting per bus cycle with round-robin on contention.
module wb_ram_arbiter
  import wb_ram_pkg::*;
#(
  parameter int adr_width = 16,
  parameter int dat_width = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [n_masters-1:0]                m_cyc_i,
  input  logic [n_masters-1:0]                m_stb_i,
  input  logic [n_masters-1:0]                m_we_i,
  input  logic [n_masters-1:0][adr_width-1:0] m_adr_i,
  input  logic [n_masters-1:0][dat_width-1:0] m_dat_w_i,
  output logic [n_masters-1:0][dat_width-1:0] m_dat_r_o,
  output logic [n_masters-1:0]                m_ack_o,
  output logic [adr_width-1:0]                ram_a_o,
  output logic [dat_width-1:0]                ram_d_o,
  input  logic [dat_width-1:0]                ram_q_i,
  output logic                                ram_cen_o,
  output logic                                ram_wen_o
);

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   winner;

  rr_grant2 u_rr_grant2 (
    .req_i    (m_cyc_i),
    .last_i   (last_q),
    .winner_o (winner)
  );

  // last resets to 1 so master 0 wins the first contention
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Outputs are gated by rst_i so a write strobed in the reset cycle never lands
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    ram_cen_o = 1'b0;
    ram_wen_o = 1'b0;
    ram_a_o   = '0;
    ram_d_o   = '0;
    m_ack_o   = '0;
    m_dat_r_o = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            owner_d = winner;
            state_d = GRANT;
          end
        end
        GRANT: begin
          if (!m_cyc_i[owner_q]) begin
            last_d  = owner_q;
            state_d = IDLE;
          end else if (m_stb_i[owner_q]) begin
            ram_cen_o = 1'b1;
            ram_wen_o = m_we_i[owner_q];
            ram_a_o   = m_adr_i[owner_q];
            ram_d_o   = m_dat_w_i[owner_q];
            state_d   = ACK;
          end
        end
        ACK: begin
          // an owner that dropped cyc here aborts and gets no ack
          m_ack_o[owner_q]   = m_cyc_i[owner_q] & m_stb_i[owner_q];
          m_dat_r_o[owner_q] = ram_q_i;
          state_d            = GRANT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter with a behavioural 64K x 16 RAM model.
module tb_wb_ram_arbiter;

  typedef struct {
    int          master;
    bit          isRead;
    logic [15:0] data;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [1:0]       mCyc, mStb, mWe, mAck;
  logic [1:0][15:0] mAdr, mDatW, mDatR;
  logic [15:0]      ramA, ramD, ramQ;
  logic             ramCen, ramWen;
  logic             preload;
  logic [15:0]      mem [0:65535];

  exp_t sbQ[$];
  int   testsRun  = 0;
  int   failCount = 0;

  wb_ram_arbiter #(.adr_width(16), .dat_width(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m_cyc_i   (mCyc),
    .m_stb_i   (mStb),
    .m_we_i    (mWe),
    .m_adr_i   (mAdr),
    .m_dat_w_i (mDatW),
    .m_dat_r_o (mDatR),
    .m_ack_o   (mAck),
    .ram_a_o   (ramA),
    .ram_d_o   (ramD),
    .ram_q_i   (ramQ),
    .ram_cen_o (ramCen),
    .ram_wen_o (ramWen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro model: registered read, write when cen & wen
  always @(posedge clk) begin
    if (preload) begin
      mem[16'h1234] <= 16'hBEEF;
      mem[16'h0010] <= 16'hAAAA;
    end else if (ramCen) begin
      if (ramWen) mem[ramA] <= ramD;
      else        ramQ <= mem[ramA];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic [15:0] adr,
                               input logic [15:0] dat);
    mCyc[m]  = cyc;
    mStb[m]  = stb;
    mWe[m]   = we;
    mAdr[m]  = adr;
    mDatW[m] = dat;
  endtask

  task automatic sbPush(input int m, input bit isRead, input logic [15:0] data);
    exp_t e;
    e.master = m;
    e.isRead = isRead;
    e.data   = data;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access for master m and wait (bounded) for its ack
  task automatic transfer(input int m, input logic we, input logic [15:0] adr,
                          input logic [15:0] dat, input logic [15:0] expData,
                          output int latency);
    applyStimulus(m, 1'b1, 1'b1, we, adr, dat);
    sbPush(m, !we, expData);
    latency = 0;
    while (latency < 20) begin
      @(negedge clk);
      latency++;
      if (mAck[m]) break;
    end
    checkOutput("ackArrived", {31'd0, mAck[m]}, 32'd1);
    tick();
  endtask

  // Count negedges (bounded) until the RAM is strobed at address adr
  task automatic waitStrobe(input logic [15:0] adr, output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (ramCen && ramA == adr) break;
    end
  endtask

  // Monitor: every ack is matched against the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (mAck[m]) begin
          checkOutput("ackExpected", {31'd0, sbQ.size() != 0}, 32'd1);
          if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("ackMaster", m, e.master);
            if (e.isRead) checkOutput("readData", {16'd0, mDatR[m]}, {16'd0, e.data});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int cyc;
    preload = 1'b1;
    rst     = 1'b1;
    mCyc = '0; mStb = '0; mWe = '0; mAdr = '0; mDatW = '0;
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 16'h0055, 16'h1111);
    repeat (3) tick();

    // Reset: all outputs held low even with a master requesting
    @(negedge clk);
    checkOutput("rstCen", {31'd0, ramCen}, 32'd0);
    checkOutput("rstAck", {30'd0, mAck}, 32'd0);
    checkOutput("rstDatR", {mDatR}, 32'd0);
    checkOutput("rstRamA", {16'd0, ramA}, 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    preload = 1'b0;
    rst     = 1'b0;
    tick();

    // Single read after reset
    $display("[TB] single read");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000);
    sbPush(0, 1'b1, 16'hBEEF);
    @(negedge clk);
    checkOutput("readIdleCen", {31'd0, ramCen}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("readStrobeCen", {31'd0, ramCen}, 32'd1);
    checkOutput("readStrobeWen", {31'd0, ramWen}, 32'd0);
    checkOutput("readStrobeAdr", {16'd0, ramA}, 32'h1234);
    checkOutput("readEarlyAck", {30'd0, mAck}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("readAck", {30'd0, mAck}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("readAckOneCycle", {30'd0, mAck}, 32'd0);
    repeat (2) tick();

    // Burst by master 1, including read-after-write
    $display("[TB] burst");
    transfer(1, 1'b1, 16'h0100, 16'h0001, 16'h0000, lat);
    checkOutput("burstFirstLatency", lat, 3);
    transfer(1, 1'b1, 16'h0101, 16'h0002, 16'h0000, lat);
    checkOutput("burstWrLatency", lat, 2);
    transfer(1, 1'b0, 16'h0100, 16'h0000, 16'h0001, lat);
    checkOutput("burstRd0Latency", lat, 2);
    transfer(1, 1'b0, 16'h0101, 16'h0000, 16'h0002, lat);
    checkOutput("burstRd1Latency", lat, 2);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) tick();

    // Contention: both request each round, both withdraw after one ack
    $display("[TB] contention");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000);
      if (r % 2 == 0) sbPush(0, 1'b1, 16'hBEEF);
      else            sbPush(1, 1'b1, 16'h0001);
      lat = 0;
      while (lat < 20) begin
        @(negedge clk);
        lat++;
        if (|mAck) break;
      end
      checkOutput("contentionLatency", lat, 3);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) tick();
    end

    // No preemption: master 0 holds cyc for 10 transfers while master 1 waits
    $display("[TB] no preemption");
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      transfer(0, 1'b1, 16'h0200 + 16'(i), 16'h0010 + 16'(i), 16'h0000, lat);
      if (i == 9) checkOutput("holdLatency", lat, 2);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    sbPush(1, 1'b1, 16'h0001);
    waitStrobe(16'h0100, cyc);
    checkOutput("handoverDelay", cyc, 3);
    tick();
    @(negedge clk);
    checkOutput("handoverAck", {30'd0, mAck}, 32'd2);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) tick();

    // Abort: master 0 drops cyc in its ACK cycle
    $display("[TB] abort");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000);
    repeat (2) tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000);
    sbPush(1, 1'b1, 16'hBEEF);
    @(negedge clk);
    checkOutput("abortNoAck", {30'd0, mAck}, 32'd0);
    waitStrobe(16'h1234, cyc);
    checkOutput("abortReleaseDelay", cyc, 3);
    tick();
    @(negedge clk);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) tick();

    // Reset in the strobe cycle of a write suppresses it
    $display("[TB] reset mid-write");
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h5555);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstWriteCen", {31'd0, ramCen}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("postRstCen", {31'd0, ramCen}, 32'd0);
    checkOutput("postRstAck", {30'd0, mAck}, 32'd0);
    checkOutput("postRstRamA", {16'd0, ramA}, 32'd0);
    checkOutput("postRstMem", {16'd0, mem[16'h0010]}, 32'hAAAA);
    tick();
    transfer(1, 1'b0, 16'h0010, 16'h0000, 16'hAAAA, lat);
    checkOutput("postRstReadLatency", lat, 3);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) tick();

    checkOutput("scoreboardDrained", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
